// File: rtl/mux_tree_pkg.sv
// Shared constants and helpers for the pipelined N-to-1 mux tree.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package mux_tree_pkg;

    localparam int DEF_WIDTH = 8;   // data bits per channel
    localparam int DEF_SEL_W = 3;   // select width, N = 2**SEL_W channels

    // Bit offset of channel c inside a flat bus of w-bit words.
    function automatic int chan_slice(input int c, input int w = DEF_WIDTH);
        return c * w;
    endfunction

endpackage

// File: rtl/mux_tree_pipe_if.sv
// Input/output handshake bundle of the mux tree: N-channel word in, one word out.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both sides; in_ready is driven by the slave.
interface mux_tree_pipe_if
    import mux_tree_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEL_W = DEF_SEL_W
);
    localparam int N = 1 << SEL_W;

    logic [WIDTH*N-1:0] in_data;
    logic [SEL_W-1:0]   in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;
    logic               out_valid;
    logic               out_ready;

    // The mux tree itself.
    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );

    // Source of channel words and sink of the selected word.
    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

endinterface

// File: rtl/mux_tree_stage.sv
// One registered level of the mux tree: IN_CH words in, IN_CH/2 words out.
// Latency: 1 cycle.
// Backpressure: hold_i freezes every register of the level (valid, data, tag).
module mux_tree_stage
    import mux_tree_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int IN_CH     = 2,
    parameter int SEL_REM_W = 1,   // select bits not yet consumed, including this level's
    parameter int TAG_W     = 1    // width of the full select tag
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          hold_i,
    input  logic                          vld_i,
    input  logic [IN_CH*WIDTH-1:0]        dat_i,
    input  logic [TAG_W-1:0]              tag_i,
    output logic                          vld_o,
    output logic [(IN_CH/2)*WIDTH-1:0]    dat_o,
    output logic [TAG_W-1:0]              tag_o
);
    localparam int OUT_CH  = IN_CH / 2;
    // The remaining select bits are the upper SEL_REM_W bits of the tag, so the
    // lowest of them drives this level and the rest ride along in the tag.
    localparam int SEL_BIT = TAG_W - SEL_REM_W;

    logic                    vld_q;
    logic [OUT_CH*WIDTH-1:0] dat_q;
    logic [OUT_CH*WIDTH-1:0] dat_d;
    logic [TAG_W-1:0]        tag_q;

    // Adjacent channel pairs (2j, 2j+1) differ only in the bit consumed here.
    always_comb begin
        dat_d = '0;
        for (int j = 0; j < OUT_CH; j++) begin
            dat_d[chan_slice(j, WIDTH) +: WIDTH] = tag_i[SEL_BIT]
                ? dat_i[chan_slice(2*j+1, WIDTH) +: WIDTH]
                : dat_i[chan_slice(2*j,   WIDTH) +: WIDTH];
        end
    end

    // Level register: loads every cycle unless the pipe is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= '0;
            tag_q <= '0;
        end else if (!hold_i) begin
            vld_q <= vld_i;
            dat_q <= dat_d;
            tag_q <= tag_i;
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;
    assign tag_o = tag_q;

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined 2**SEL_W-to-1 mux tree with select tag; optional scan select via MUX_TREE_PIPE_SCAN_EN.
// Latency: SEL_W cycles from accept to out_valid, one word per cycle.
// Backpressure: whole pipe holds while out_valid && !out_ready; in_ready is its inverse.
module mux_tree_pipe
    import mux_tree_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef MUX_TREE_PIPE_SCAN_EN
    input  logic            scan_mode,
`endif
    mux_tree_pipe_if.slave  bus
);
    localparam int N = 1 << SEL_W;

    // All level buses packed back to back: level 0 is the input (N words),
    // level k carries N/2**k words, the last level is the single output word.
    localparam int TOT_W    = (2*N - 1) * WIDTH;
    localparam int LAST_OFF = (2*N - 2) * WIDTH;

    logic             stall;
    logic [SEL_W-1:0] eff_sel;
    logic [TOT_W-1:0] lvl_dat;
    logic [SEL_W:0]   lvl_vld;
    logic [SEL_W-1:0] lvl_tag [0:SEL_W];

    assign stall       = bus.out_valid && !bus.out_ready;
    assign bus.in_ready = !stall;

`ifdef MUX_TREE_PIPE_SCAN_EN
    logic [SEL_W-1:0] scan_cnt_q;
    logic [SEL_W-1:0] scan_cnt_d;

    // Scan counter advances only on words actually accepted in scan mode;
    // it wraps naturally at N and is left alone when scan mode is dropped.
    always_comb begin
        scan_cnt_d = scan_cnt_q;
        if (scan_mode && bus.in_valid && !stall) begin
            scan_cnt_d = scan_cnt_q + 1'b1;
        end
    end

    // Scan counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
        end else begin
            scan_cnt_q <= scan_cnt_d;
        end
    end

    assign eff_sel = scan_mode ? scan_cnt_q : bus.in_sel;
`else
    assign eff_sel = bus.in_sel;
`endif

    assign lvl_dat[N*WIDTH-1:0] = bus.in_data;
    assign lvl_vld[0]           = bus.in_valid;
    assign lvl_tag[0]           = eff_sel;

    generate
        for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
            localparam int IN_CH   = N >> k;
            localparam int IN_OFF  = (2*N - ((2*N) >> k)) * WIDTH;
            localparam int OUT_OFF = (2*N - (N >> k)) * WIDTH;

            mux_tree_stage #(
                .WIDTH     (WIDTH),
                .IN_CH     (IN_CH),
                .SEL_REM_W (SEL_W - k),
                .TAG_W     (SEL_W)
            ) u_stage (
                .clk    (clk),
                .rst_n  (rst_n),
                .hold_i (stall),
                .vld_i  (lvl_vld[k]),
                .dat_i  (lvl_dat[IN_OFF +: IN_CH*WIDTH]),
                .tag_i  (lvl_tag[k]),
                .vld_o  (lvl_vld[k+1]),
                .dat_o  (lvl_dat[OUT_OFF +: (IN_CH/2)*WIDTH]),
                .tag_o  (lvl_tag[k+1])
            );
        end
    endgenerate

    assign bus.out_data  = lvl_dat[LAST_OFF +: WIDTH];
    assign bus.out_valid = lvl_vld[SEL_W];
    assign bus.out_sel   = lvl_tag[SEL_W];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed bench for mux_tree_pipe (WIDTH=8, SEL_W=3); scan test built when MUX_TREE_PIPE_SCAN_EN is defined.
// Latency expected: 3 cycles.
// Backpressure exercised with out_ready stall windows.
module tb_mux_tree_pipe;

    localparam int WIDTH = 8;
    localparam int SEL_W = 3;
    localparam int N     = 1 << SEL_W;

    typedef struct {
        logic [7:0]       base;     // channel c carries base + c
        logic [SEL_W-1:0] sel;
        logic [7:0]       exp_dat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mux_tree_pipe_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

`ifdef MUX_TREE_PIPE_SCAN_EN
    logic scan_mode;
`endif

    mux_tree_pipe #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef MUX_TREE_PIPE_SCAN_EN
        .scan_mode (scan_mode),
`endif
        .bus       (bus)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [7:0] base);
        for (int c = 0; c < N; c++) begin
            bus.in_data[c*WIDTH +: WIDTH] = base + 8'(c);
        end
    endtask

    // Stream nw words with out_ready low on cycles s_lo..s_hi. Word i must
    // come out as channel i mod N; in scan mode in_sel is held at 0.
    task automatic run_stream(input string nm, input logic [7:0] base, input int nw,
                              input int s_lo, input int s_hi, input bit scan);
        int   issued = 0;
        int   got    = 0;
        logic acc;
        logic [7:0] exp_d;
        fill(base);
`ifdef MUX_TREE_PIPE_SCAN_EN
        scan_mode = scan;
`endif
        for (int cyc = 1; cyc <= nw + s_hi + 8; cyc++) begin
            bus.out_ready = !(cyc >= s_lo && cyc <= s_hi);
            bus.in_valid  = (issued < nw);
            bus.in_sel    = scan ? '0 : SEL_W'(issued % N);
            #1;
            exp_d = base + 8'(got % N);
            if (bus.out_valid && !bus.out_ready) begin
                check({nm, "_rdy_stall"}, 32'(bus.in_ready), 32'd0);
                check({nm, "_hold"}, 32'(bus.out_data), 32'(exp_d));
            end else begin
                check({nm, "_rdy"}, 32'(bus.in_ready), 32'd1);
            end
            if (bus.out_valid && bus.out_ready) begin
                check({nm, "_dat"}, 32'(bus.out_data), 32'(exp_d));
                check({nm, "_sel"}, 32'(bus.out_sel), 32'(got % N));
                got++;
            end
            acc = bus.in_valid && bus.in_ready;
            tick();
            if (acc) issued++;
        end
        bus.in_valid = 1'b0;
        check({nm, "_count"}, 32'(got), 32'(nw));
        check({nm, "_issued"}, 32'(issued), 32'(nw));
`ifdef MUX_TREE_PIPE_SCAN_EN
        scan_mode = 1'b0;
`endif
    endtask

    initial begin
        vec_t vecs [7];
        int   nvld;

        vecs[0] = '{8'h10, 3'd5, 8'h15};
        vecs[1] = '{8'h10, 3'd0, 8'h10};
        vecs[2] = '{8'h10, 3'd7, 8'h17};
        vecs[3] = '{8'hA0, 3'd3, 8'hA3};
        vecs[4] = '{8'hF8, 3'd7, 8'hFF};
        vecs[5] = '{8'h00, 3'd2, 8'h02};
        vecs[6] = '{8'h5A, 3'd6, 8'h60};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sel    = '0;
        bus.out_ready = 1'b1;
        fill(8'h10);
`ifdef MUX_TREE_PIPE_SCAN_EN
        scan_mode = 1'b0;
`endif

        // Reset state
        tick();
        tick();
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data",  32'(bus.out_data),  32'd0);
        check("rst_sel",   32'(bus.out_sel),   32'd0);
        check("rst_ready", 32'(bus.in_ready),  32'd1);
        rst_n = 1'b1;
        tick();

        // Single words: latency, selection and one-cycle valid
        for (int i = 0; i < 7; i++) begin
            fill(vecs[i].base);
            bus.in_sel   = vecs[i].sel;
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            tick();
            check("vec_early", 32'(bus.out_valid), 32'd0);
            tick();
            check("vec_valid", 32'(bus.out_valid), 32'd1);
            check("vec_data",  32'(bus.out_data),  32'(vecs[i].exp_dat));
            check("vec_sel",   32'(bus.out_sel),   32'(vecs[i].sel));
            tick();
            check("vec_valid_gone", 32'(bus.out_valid), 32'd0);
        end

        // Back-to-back sweep 0..7
        fill(8'h10);
        bus.out_ready = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            bus.in_valid = (t <= 8);
            bus.in_sel   = SEL_W'(t - 1);
            tick();
            if (t >= 3 && t <= 10) begin
                check("stream_valid", 32'(bus.out_valid), 32'd1);
                check("stream_data",  32'(bus.out_data),  32'h10 + 32'(t - 3));
            end else begin
                check("stream_idle", 32'(bus.out_valid), 32'd0);
            end
        end
        bus.in_valid = 1'b0;

        // Backpressure: 4 words, out_ready low on cycles 4..7
        run_stream("bp", 8'h20, 4, 4, 7, 1'b0);

        // Asynchronous reset with three words in flight
        fill(8'h40);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_sel   = SEL_W'(i + 1);
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("arst_pre_valid", 32'(bus.out_valid), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid_now", 32'(bus.out_valid), 32'd0);
        check("arst_data_now",  32'(bus.out_data),  32'd0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        nvld = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.out_valid) nvld++;
        end
        check("arst_no_stale", 32'(nvld), 32'd0);

`ifdef MUX_TREE_PIPE_SCAN_EN
        // Scan: counter drives the select, stall on cycles 6..8 must not advance it
        run_stream("scan", 8'h30, 10, 6, 8, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
